// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: loads A, B and an opcode from one shared bus, drives the ALU, and registers its result
//   clk, rst_n (async, active low)
//   data_in       shared bus: A, then B, then the opcode (low COD_OP bits)
//   load          load strobe (raw level button when LOAD_EDGE_DETECT_EN is defined)
//   clear         synchronous restart of the sequence, wins over load
//   alu_result    combinational result from the ALU
//   operando_A/B, cod_operacion   registered ALU inputs
//   result_out, result_valid, op_error, state_leds (one-hot WAIT_A/WAIT_B/WAIT_OP)
// Optional macro: LOAD_EDGE_DETECT_EN (2-flop synchronizer plus rising-edge detect on load)
module alu_operand_sequencer #(
    parameter int NBITS  = 8,
    parameter int COD_OP = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NBITS-1:0]  data_in,
    input  logic              load,
    input  logic              clear,
    input  logic [NBITS-1:0]  alu_result,
    output logic [NBITS-1:0]  operando_A,
    output logic [NBITS-1:0]  operando_B,
    output logic [COD_OP-1:0] cod_operacion,
    output logic [NBITS-1:0]  result_out,
    output logic              result_valid,
    output logic              op_error,
    output logic [2:0]        state_leds
);
    typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, EXEC, DONE} state_t;
    state_t state_q, state_d;
    logic [NBITS-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [COD_OP-1:0] op_q, op_d, op_in;
    logic valid_q, valid_d, err_q, err_d, load_ev, op_ok;
`ifdef LOAD_EDGE_DETECT_EN
    // sync_q[1:0] is the synchronizer; sync_q[2] remembers the previous synchronized level
    logic [2:0] sync_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[1:0], load};
    end
    assign load_ev = sync_q[1] & ~sync_q[2];
`else
    assign load_ev = load;
`endif
    assign op_in = data_in[COD_OP-1:0];
    assign op_ok = op_in == COD_OP'(6'b100000) || op_in == COD_OP'(6'b100010) ||
                   op_in == COD_OP'(6'b100100) || op_in == COD_OP'(6'b100101) ||
                   op_in == COD_OP'(6'b100110) || op_in == COD_OP'(6'b000011) ||
                   op_in == COD_OP'(6'b000010) || op_in == COD_OP'(6'b100111);
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        valid_d = valid_q;
        err_d   = err_q;
        if (clear) begin
            state_d = WAIT_A;
            valid_d = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                WAIT_A, DONE: if (load_ev) begin
                    a_d     = data_in;
                    valid_d = 1'b0;
                    state_d = WAIT_B;
                end
                WAIT_B: if (load_ev) begin
                    b_d     = data_in;
                    state_d = WAIT_OP;
                end
                WAIT_OP: if (load_ev) begin
                    op_d    = op_in;
                    err_d   = ~op_ok;
                    state_d = EXEC;
                end
                // opcode has been stable at the ALU for a full cycle; loads here are dropped
                EXEC: begin
                    res_d   = alu_result;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
                default: state_d = WAIT_A;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end
    assign operando_A    = a_q;
    assign operando_B    = b_q;
    assign cod_operacion = op_q;
    assign result_out    = res_q;
    assign result_valid  = valid_q;
    assign op_error      = err_q;
    assign state_leds    = {state_q == WAIT_OP, state_q == WAIT_B, state_q == WAIT_A};
endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
- Front-end driver for the combinational ALU. Takes the ALU's operands and opcode in sequence from one shared switch/data bus, using a load strobe.
- Presents the stable operands and opcode to the ALU, captures the ALU result into a register, and flags completion.
- Sits between the board I/O (switches, button, LEDs) and the ALU.

Parameters:
- NBITS, 8, operand/result width; must match the ALU.
- COD_OP, 6, opcode width; must match the ALU.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  NBITS  shared switch bus; carries A, then B, then the opcode (low COD_OP bits).
- load  in  1  load strobe; see Optional Feature for its form.
- clear  in  1  synchronous restart of the sequence.
- alu_result  in  NBITS  combinational result returned by the ALU.
- operando_A  out  NBITS  registered operand A to the ALU.
- operando_B  out  NBITS  registered operand B to the ALU.
- cod_operacion  out  COD_OP  registered opcode to the ALU.
- result_out  out  NBITS  registered copy of alu_result.
- result_valid  out  1  result_out holds the result of the current sequence.
- op_error  out  1  the loaded opcode is not one of the eight supported codes.
- state_leds  out  3  one-hot: bit0 WAIT_A, bit1 WAIT_B, bit2 WAIT_OP; all 0 in EXEC/DONE.

Behaviour:
- Reset (async, rst_n=0): all data outputs 0, result_valid=0, op_error=0, state=WAIT_A, state_leds=3'b001.
- "Load event": one accepted strobe cycle, as defined under Optional Feature.
- State transitions:
  - WAIT_A: on a load event, operando_A<=data_in; go to WAIT_B.
  - WAIT_B: on a load event, operando_B<=data_in; go to WAIT_OP.
  - WAIT_OP: on a load event, cod_operacion<=data_in[COD_OP-1:0]; op_error<=1 if the value is not in {100000,100010,100100,100101,100110,000011,000010,100111}, else 0; go to EXEC.
  - EXEC: exactly one cycle. The opcode is now stable at the ALU. result_out<=alu_result; result_valid<=1; go to DONE.
  - DONE: hold all outputs. A load event here behaves as WAIT_A: it captures A, clears result_valid, and goes to WAIT_B.
- Latency: result_valid rises 2 clk after the opcode load-event cycle.
- Invalid opcode: still executes. result_out takes whatever the ALU drives (all ones by ALU definition); op_error stays set until the next opcode load or clear.
- Operand and opcode registers only change on their own load event. The ALU inputs are therefore glitch-free between loads.
- clear (synchronous): has priority over load in the same cycle. Returns to WAIT_A, result_valid=0, op_error=0. operando_A/B, cod_operacion and result_out keep their values.
- Load events in EXEC are ignored (dropped, not queued).
- Reset mid-sequence: immediate return to the reset state; no partial state survives.
- No arithmetic is performed in this block; widths pass straight through with no sign extension.

Optional Feature:
- Macro: LOAD_EDGE_DETECT_EN.
- Defined: load is a raw, level button input. It is passed through a 2-flop synchronizer, and a load event is the rising edge of the synchronized signal. Holding the button gives exactly one event. Events are delayed 2 cycles from the raw input. Synchronizer flops reset to 0.
- Undefined: load is already a clean single-cycle strobe from upstream; every cycle with load=1 is a load event, with no added delay.

Test Plan:
- Reset, then load A=8'h05, B=8'h03, op=6'b100000 → result_out=8'h08 two cycles after the op load; result_valid=1; op_error=0; state_leds=000.
- A=8'h80, B=8'h02, op=SRA (000011) → result_out=8'hE0; then op SRL with the same operands → result_out=8'h20.
- Op=6'b111111 → op_error=1, result_out=8'hFF, result_valid=1.
- Assert clear in WAIT_OP together with load=1 → state WAIT_A; cod_operacion unchanged; result_valid=0.
- Pulse rst_n low while in WAIT_B → all outputs 0 immediately; state_leds=001.
- With LOAD_EDGE_DETECT_EN defined, hold load high for 10 cycles in WAIT_A → only A is captured; state WAIT_B; B unchanged.
